matrix_loader: RTL and testbench
================================

// Module: matrix_loader
// PURPOSE
//  Upstream feeder for the 8x8 matrix multiplier. Accepts a byte stream (valid/ready),
//  writes 64 A elements then 64 B elements (both row-major) into the A/B RAM write ports,
//  pulses mm_start, waits for mm_done, clears the multiplier, then accepts the next frame.
// PARAMETERS
//  DATA_W  8   element width (signed, two's complement; passed through unmodified)
//  DIM     8   matrix dimension; DIM*DIM elements per matrix; must be a power of two
//  ADDR_W  6   RAM address width = log2(DIM*DIM)
// PORTS
//  clk         in   1       clock
//  reset       in   1       synchronous, active-high
//  s_data      in   DATA_W  stream element
//  s_valid     in   1       s_data valid
//  s_ready     out  1       loader accepts; transfer = s_valid & s_ready
//  ram_a_addr  out  ADDR_W  A RAM write address
//  ram_a_data  out  DATA_W  A RAM write data
//  ram_a_we    out  1       A RAM write enable
//  ram_b_addr  out  ADDR_W  B RAM write address
//  ram_b_data  out  DATA_W  B RAM write data
//  ram_b_we    out  1       B RAM write enable
//  mm_start    out  1       one-cycle start pulse to multiplier
//  mm_done     in   1       multiplier done (level, sticky until multiplier reset)
//  mm_clear    out  1       one-cycle reset pulse to multiplier after done
//  busy        out  1       high in START/WAIT/CLEAR
//  frame_cnt   out  8       completed multiplications, wraps 255->0
//  err         out  1       checksum error, sticky (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=LOAD_A, idx=0; all outputs 0 during reset cycle; s_ready=1 first cycle after.
//  - States: LOAD_A -> LOAD_B -> [CHK] -> START -> WAIT -> CLEAR -> LOAD_A.
//  - LOAD_A/LOAD_B(/CHK): s_ready=1; elsewhere s_ready=0. Stalls (s_valid=0) hold state.
//  - idx (ADDR_W bits) increments per transfer; at idx=DIM*DIM-1 transfer, idx wraps to 0
//    and state advances. Transfer k of A -> A addr k; of B -> B addr k.
//  - Write latency 1: transfer at cycle t gives addr/data/we=1 at t+1 for exactly one cycle;
//    we=0 otherwise; addr/data hold last value when we=0.
//  - START: mm_start=1 for one cycle, then WAIT. WAIT holds until mm_done=1.
//  - CLEAR: mm_clear=1 one cycle, frame_cnt+=1 (mod 256), then LOAD_A.
//  - mm_done high outside WAIT is ignored. Reset mid-frame discards partial frame;
//    frame_cnt and err return to 0.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//   - 8-bit running sum (mod 256) of all 2*DIM*DIM data bytes; cleared entering LOAD_A.
//   - CHK state accepts one extra byte; equal to sum -> START; mismatch -> err=1 (sticky
//     until reset), no mm_start, return to LOAD_A (next frame accepted normally).
//  Not defined: no CHK state, LOAD_B -> START directly, err tied 0.
// TESTING
//  1. Reset, stream A=k (0..63), B=-k, no stalls -> A addr k=k, B addr k=-k, 128 we
//     pulses, mm_start 1 cycle after final B write.
//  2. Random s_valid gaps (~50%) -> identical RAM contents; s_ready=0 in START/WAIT.
//  3. Hold mm_done=0 for 500 cycles -> stays WAIT, s_ready=0; mm_done=1 -> mm_clear
//     pulse next cycle, frame_cnt=1, s_ready=1 the cycle after.
//  4. Reset asserted after 40 A bytes -> no further we, next frame starts at A addr 0,
//     frame_cnt=0.
//  5. 256 back-to-back frames -> frame_cnt wraps to 0.
//  6. (LOADER_CHECKSUM_EN) all-1 data, checksum 0x80 -> start; checksum 0x81 -> err=1,
//     no mm_start, next good frame still starts, err stays 1.

Source files
------------

// File: rtl/matrix_loader.sv
// Stream-to-RAM feeder for the 8x8 matrix multiplier: loads A then B, starts, waits, clears.
// Optional trailing checksum byte per frame when LOADER_CHECKSUM_EN is defined.
module matrix_loader #(
  parameter int DATA_W = 8,
  parameter int DIM    = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] ram_a_addr,
  output logic [DATA_W-1:0] ram_a_data,
  output logic              ram_a_we,
  output logic [ADDR_W-1:0] ram_b_addr,
  output logic [DATA_W-1:0] ram_b_data,
  output logic              ram_b_we,
  output logic              mm_start,
  input  logic              mm_done,
  output logic              mm_clear,
  output logic              busy,
  output logic [7:0]        frame_cnt,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DIM*DIM-1);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, CHK, START, WAIT, CLEAR} state_t;

  state_t            state, next;
  logic [ADDR_W-1:0] idx;
  logic              load, xfer, last;
  logic              a_we_q, b_we_q, start_q;

  always_comb begin
    load = (state == LOAD_A) || (state == LOAD_B);
`ifdef LOADER_CHECKSUM_EN
    load = load || (state == CHK);
`endif
  end

  // Strobes are masked during reset so nothing leaks out in the reset cycle itself.
  assign s_ready  = load & ~reset;
  assign xfer     = s_valid & s_ready;
  assign last     = (idx == LAST);
  assign busy     = ((state == START) || (state == WAIT) || (state == CLEAR)) & ~reset;
  assign mm_clear = (state == CLEAR) & ~reset;
  assign ram_a_we = a_we_q & ~reset;
  assign ram_b_we = b_we_q & ~reset;
  assign mm_start = start_q & ~reset;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       sum_ok;
  assign sum_ok = (8'(s_data) == sum);
`endif

  always_comb begin
    next = state;
    case (state)
      LOAD_A: if (xfer && last) next = LOAD_B;
`ifdef LOADER_CHECKSUM_EN
      LOAD_B: if (xfer && last) next = CHK;
      CHK:    if (xfer) next = sum_ok ? START : LOAD_A;
`else
      LOAD_B: if (xfer && last) next = START;
`endif
      START:  next = WAIT;
      WAIT:   if (mm_done) next = CLEAR;
      CLEAR:  next = LOAD_A;
      default: next = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD_A;
      idx        <= '0;
      ram_a_addr <= '0;
      ram_a_data <= '0;
      a_we_q     <= 1'b0;
      ram_b_addr <= '0;
      ram_b_data <= '0;
      b_we_q     <= 1'b0;
      start_q    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state   <= next;
      a_we_q  <= xfer && (state == LOAD_A);
      b_we_q  <= xfer && (state == LOAD_B);
      // Start is issued the cycle after the final write lands in RAM.
      start_q <= (state == START);
      if (xfer && load && (state != CHK))
        idx <= last ? '0 : idx + 1'b1;
      if (xfer && (state == LOAD_A)) begin
        ram_a_addr <= idx;
        ram_a_data <= s_data;
      end
      if (xfer && (state == LOAD_B)) begin
        ram_b_addr <= idx;
        ram_b_data <= s_data;
      end
      if (state == CLEAR)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      if (next == LOAD_A && state != LOAD_A)
        sum <= '0;
      else if (xfer && (state != CHK))
        sum <= sum + 8'(s_data);
      if (xfer && (state == CHK) && !sum_ok)
        err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: expected RAM writes queued at transfer time,
// popped when the write strobes appear; includes a small multiplier done/clear model.
module tb_matrix_loader;
  logic       clk = 1'b0, reset = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0, mm_done = 1'b0;
  logic       s_ready, ram_a_we, ram_b_we, mm_start, mm_clear, busy, err;
  logic [5:0] ram_a_addr, ram_b_addr;
  logic [7:0] ram_a_data, ram_b_data, frame_cnt;

  matrix_loader dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ram_a_addr(ram_a_addr), .ram_a_data(ram_a_data), .ram_a_we(ram_a_we),
    .ram_b_addr(ram_b_addr), .ram_b_data(ram_b_data), .ram_b_we(ram_b_we),
    .mm_start(mm_start), .mm_done(mm_done), .mm_clear(mm_clear), .busy(busy),
    .frame_cnt(frame_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int wa = 0, wb = 0, starts = 0, cyc = 0, last_b = 0, pend = 0;
  bit auto_done = 1'b1, gap_chk = 1'b0;
  logic [13:0] qa[$], qb[$];
  logic [13:0] ea, eb;
`ifdef LOADER_CHECKSUM_EN
  int chk_adj = 0;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Write monitor, start-gap check and multiplier done/clear model.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (ram_a_we) begin
      wa++;
      if (qa.size() == 0) check("a_unexpected_we", 1, 0);
      else begin
        ea = qa.pop_front();
        check("a_addr", 32'(ram_a_addr), 32'(ea[13:8]));
        check("a_data", 32'(ram_a_data), 32'(ea[7:0]));
      end
    end
    if (ram_b_we) begin
      wb++;
      last_b = cyc;
      if (qb.size() == 0) check("b_unexpected_we", 1, 0);
      else begin
        eb = qb.pop_front();
        check("b_addr", 32'(ram_b_addr), 32'(eb[13:8]));
        check("b_data", 32'(ram_b_data), 32'(eb[7:0]));
      end
    end
    if (mm_start) begin
      starts++;
      if (gap_chk) check("start_gap", cyc - last_b, 1);
      pend = 3;
    end
    if (busy) check("ready_while_busy", 32'(s_ready), 0);
    if (mm_clear) mm_done = 1'b0;
    else if (auto_done && pend > 0) begin
      pend--;
      if (pend == 0) mm_done = 1'b1;
    end
  end

  task automatic send(input logic [7:0] d, input int gap, input int mat, input int k);
    int n = 0;
    while ($urandom_range(99) < gap) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("send_timeout", 0, 1);
    else if (mat == 0) qa.push_back({6'(k), d});
    else if (mat == 1) qb.push_back({6'(k), d});
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // pat 0: A=k, B=-k; pat 1: random; pat 2: all ones
  task automatic frame(input int pat, input int gap);
    logic [7:0] d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum = '0;
`endif
    for (int k = 0; k < 128; k++) begin
      d = (pat == 0) ? ((k < 64) ? 8'(k) : 8'(64 - k)) : (pat == 2) ? 8'd1 : 8'($urandom);
      send(d, gap, (k < 64) ? 0 : 1, k % 64);
`ifdef LOADER_CHECKSUM_EN
      sum += d;
`endif
    end
`ifdef LOADER_CHECKSUM_EN
    send(sum + 8'(chk_adj), gap, 2, 0);
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("back_to_load", 32'(s_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0, s0, bad, n;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_a_we", 32'(ram_a_we), 0);
    check("rst_b_we", 32'(ram_b_we), 0);
    check("rst_start", 32'(mm_start), 0);
    check("rst_clear", 32'(mm_clear), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_err", 32'(err), 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(s_ready), 1);

    // Ramp frame, no stalls
`ifndef LOADER_CHECKSUM_EN
    gap_chk = 1'b1;
`endif
    w0 = wa + wb; s0 = starts;
    frame(0, 0);
    wait_idle();
    gap_chk = 1'b0;
    check("we_pulses", wa + wb - w0, 128);
    check("start_once", starts - s0, 1);
    check("frame_cnt_1", 32'(frame_cnt), 1);

    // Random data with ~50% valid gaps
    frame(1, 50);
    wait_idle();
    check("frame_cnt_2", 32'(frame_cnt), 2);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);

    // Multiplier holds done low for 500 cycles
    auto_done = 1'b0; s0 = starts;
    frame(1, 0);
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    check("reached_busy", 32'(busy), 1);
    repeat (2) @(negedge clk);
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (s_ready || mm_clear || !busy) bad++;
    end
    check("wait_hold", bad, 0);
    check("wait_start_once", starts - s0, 1);
    mm_done = 1'b1;
    @(negedge clk);
    check("clear_pulse", 32'(mm_clear), 1);
    check("clear_not_ready", 32'(s_ready), 0);
    @(negedge clk);
    check("ready_after_clear", 32'(s_ready), 1);
    check("clear_one_cycle", 32'(mm_clear), 0);
    check("frame_cnt_3", 32'(frame_cnt), 3);
    pend = 0;
    auto_done = 1'b1;

    // Reset mid A matrix
    for (int k = 0; k < 40; k++) send(8'(k + 7), 0, 0, k);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_a_we", 32'(ram_a_we), 0);
    check("midrst_ready", 32'(s_ready), 0);
    check("midrst_frame_cnt", 32'(frame_cnt), 0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_qa_empty", qa.size(), 0);
    frame(0, 0);
    wait_idle();
    check("post_rst_frame_cnt", 32'(frame_cnt), 1);

    // Frame counter wrap
    repeat (254) frame(1, 0);
    wait_idle();
    check("frame_cnt_255", 32'(frame_cnt), 255);
    frame(1, 0);
    wait_idle();
    check("frame_cnt_wrap", 32'(frame_cnt), 0);

`ifdef LOADER_CHECKSUM_EN
    s0 = starts; chk_adj = 0;
    frame(2, 0);
    wait_idle();
    check("chk_good_start", starts - s0, 1);
    check("chk_good_err", 32'(err), 0);
    s0 = starts; chk_adj = 1;
    frame(2, 0);
    wait_idle();
    check("chk_bad_no_start", starts - s0, 0);
    check("chk_bad_err", 32'(err), 1);
    s0 = starts; chk_adj = 0;
    frame(2, 0);
    wait_idle();
    check("chk_recover_start", starts - s0, 1);
    check("chk_err_sticky", 32'(err), 1);
`endif
    check("final_qa_empty", qa.size() + qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
